// File: rtl/icache_line_fill.sv
// rtl/icache_line_fill.sv - I-cache line-fill engine: invalidate victim, fetch 4 words, fill set, retag.
// Optional feature: ICACHE_CRITICAL_WORD_FIRST_EN (critical-word-first fetch order plus early-restart outputs).
module icache_line_fill #(
    parameter int PABITS   = 36,
    parameter int WAY_BITS = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                start_i,
    input  logic [PABITS-1:0]   paddr_i,
    input  logic [WAY_BITS-1:0] way_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [WAY_BITS-1:0] fill_way_o,
    output logic [PABITS-13:0]  fill_tag_o,
    output logic [7:0]          fill_index_o,
    output logic                invalidate_line_o,
    output logic                validate_line_o,
    output logic                fill_line_o,
    output logic [7:0]          line_index_o,
    output logic [1:0]          line_offset_o,
    output logic [31:0]         line_in_o,
    output logic                mem_read_o,
    output logic [PABITS-1:0]   mem_address_o,
    input  logic                mem_ready_i,
    input  logic [31:0]         mem_data_in_i
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    ,
    output logic                crit_valid_o,
    output logic [31:0]         crit_word_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_INVAL    = 2'd1,
        S_FETCH    = 2'd2,
        S_VALIDATE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [1:0]            cnt_q;
    logic [1:0]            addr_off_q;
    logic [PABITS-13:0]    fill_tag_q;
    logic [7:0]            fill_index_q;
    logic [WAY_BITS-1:0]   fill_way_q;
    logic [31:0]           line_in_q;
    logic [1:0]            line_offset_q;
    logic                  fill_line_q;
    logic                  accept;
    logic                  ack;
    logic [1:0]            first_off;

    // Byte-offset bits never reach memory; the word-offset bits are only used for critical-word-first.
    logic unused_paddr_low;
    assign unused_paddr_low = ^paddr_i[3:0];

    assign accept = (state_q == S_IDLE) && start_i;
    assign ack    = (state_q == S_FETCH) && mem_ready_i;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign first_off = paddr_i[3:2];
`else
    assign first_off = 2'b00;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start_i) state_d = S_INVAL;
            S_INVAL:    state_d = S_FETCH;
            S_FETCH:    if (mem_ready_i && (cnt_q == 2'd3)) state_d = S_VALIDATE;
            S_VALIDATE: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // Each ack is registered so the set sees FillLine one cycle later; the 4th lands with VALIDATE.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q         <= 2'd0;
            addr_off_q    <= 2'd0;
            fill_tag_q    <= '0;
            fill_index_q  <= 8'd0;
            fill_way_q    <= '0;
            line_in_q     <= 32'd0;
            line_offset_q <= 2'd0;
            fill_line_q   <= 1'b0;
        end else begin
            fill_line_q <= ack;
            if (accept) begin
                fill_tag_q   <= paddr_i[PABITS-1:12];
                fill_index_q <= paddr_i[11:4];
                fill_way_q   <= way_i;
                addr_off_q   <= first_off;
                cnt_q        <= 2'd0;
            end
            if (ack) begin
                line_in_q     <= mem_data_in_i;
                line_offset_q <= addr_off_q;
                addr_off_q    <= addr_off_q + 2'd1;
                cnt_q         <= cnt_q + 2'd1;
            end
        end
    end

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic crit_valid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            crit_valid_q <= 1'b0;
        end else begin
            crit_valid_q <= ack && (cnt_q == 2'd0);
        end
    end

    assign crit_valid_o = crit_valid_q;
    assign crit_word_o  = line_in_q;
`endif

    always_comb begin
        busy_o            = (state_q != S_IDLE);
        invalidate_line_o = (state_q == S_INVAL);
        mem_read_o        = (state_q == S_FETCH);
        validate_line_o   = (state_q == S_VALIDATE);
        done_o            = (state_q == S_VALIDATE);
        fill_line_o       = fill_line_q;
        fill_way_o        = fill_way_q;
        fill_tag_o        = fill_tag_q;
        fill_index_o      = fill_index_q;
        line_index_o      = fill_index_q;
        line_offset_o     = line_offset_q;
        line_in_o         = line_in_q;
        mem_address_o     = {fill_tag_q, fill_index_q, addr_off_q, 2'b00};
    end

endmodule

// File: tb/tb_icache_line_fill.sv
// tb/tb_icache_line_fill.sv - directed self-checking bench for icache_line_fill.
module tb_icache_line_fill;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [35:0] paddr;
    logic [1:0]  way;
    logic        busy, done;
    logic [1:0]  fill_way;
    logic [23:0] fill_tag;
    logic [7:0]  fill_index;
    logic        inval, valid_line, fill_line;
    logic [7:0]  line_index;
    logic [1:0]  line_offset;
    logic [31:0] line_in;
    logic        mem_read;
    logic [35:0] mem_address;
    logic        mem_ready;
    logic [31:0] mem_data;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    logic        crit_valid;
    logic [31:0] crit_word;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    icache_line_fill #(.PABITS(36), .WAY_BITS(2)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .start_i           (start),
        .paddr_i           (paddr),
        .way_i             (way),
        .busy_o            (busy),
        .done_o            (done),
        .fill_way_o        (fill_way),
        .fill_tag_o        (fill_tag),
        .fill_index_o      (fill_index),
        .invalidate_line_o (inval),
        .validate_line_o   (valid_line),
        .fill_line_o       (fill_line),
        .line_index_o      (line_index),
        .line_offset_o     (line_offset),
        .line_in_o         (line_in),
        .mem_read_o        (mem_read),
        .mem_address_o     (mem_address),
        .mem_ready_i       (mem_ready),
        .mem_data_in_i     (mem_data)
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        ,
        .crit_valid_o      (crit_valid),
        .crit_word_o       (crit_word)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " done"}, done, 0);
        chk({tag, " inval"}, inval, 0);
        chk({tag, " validate"}, valid_line, 0);
        chk({tag, " fill_line"}, fill_line, 0);
        chk({tag, " mem_read"}, mem_read, 0);
        chk({tag, " mem_address"}, mem_address, 0);
        chk({tag, " line_in"}, line_in, 0);
        chk({tag, " line_offset"}, line_offset, 0);
        chk({tag, " fill_tag"}, fill_tag, 0);
        chk({tag, " fill_index"}, fill_index, 0);
        chk({tag, " fill_way"}, fill_way, 0);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        chk({tag, " crit_valid"}, crit_valid, 0);
        chk({tag, " crit_word"}, crit_word, 0);
`endif
    endtask

    // One complete fill; data is 4x32 packed (word i at [i*32 +: 32]), gaps is 4x4 idle cycles before each ack.
    task automatic do_fill(input string tag, input logic [35:0] pa, input logic [1:0] w,
                           input logic [127:0] data, input logic [15:0] gaps,
                           input bit hold, input bit stray);
        logic [1:0]  so, off, poff;
        logic [31:0] pdata, dw;
        bit          pack;
        int          ng;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        so = pa[3:2];
`else
        so = 2'b00;
`endif
        poff = 2'b00;
        pdata = 32'd0;
        start = 1'b1; paddr = pa; way = w; mem_ready = 1'b0;
        tick;
        if (!hold) start = 1'b0;
        paddr = pa ^ 36'hF_FFFF_FFF0;
        way = ~w;
        chk({tag, " inval"}, inval, 1);
        chk({tag, " busy"}, busy, 1);
        chk({tag, " inval mem_read"}, mem_read, 0);
        chk({tag, " fill_tag"}, fill_tag, pa[35:12]);
        chk({tag, " fill_index"}, fill_index, pa[11:4]);
        chk({tag, " line_index"}, line_index, pa[11:4]);
        chk({tag, " fill_way"}, fill_way, w);
        mem_ready = stray;
        mem_data = 32'hDEAD_BEEF;
        tick;
        pack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ng = int'(gaps[i*4 +: 4]);
            dw = data[i*32 +: 32];
            off = so + 2'(i);
            for (int g = 0; g <= ng; g++) begin
                mem_ready = (g == ng);
                mem_data = mem_ready ? dw : (32'hBAD0_0000 | 32'(g));
                chk({tag, " mem_read"}, mem_read, 1);
                chk({tag, " mem_address"}, mem_address, {pa[35:4], off, 2'b00});
                chk({tag, " fetch inval"}, inval, 0);
                chk({tag, " fetch done"}, done, 0);
                chk({tag, " fill_line"}, fill_line, pack);
                if (pack) begin
                    chk({tag, " line_offset"}, line_offset, poff);
                    chk({tag, " line_in"}, line_in, pdata);
                end
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
                chk({tag, " crit_valid"}, crit_valid, pack && (poff == so));
                if (pack && (poff == so)) chk({tag, " crit_word"}, crit_word, pdata);
`endif
                tick;
                pack = mem_ready;
                poff = off;
                pdata = dw;
            end
        end
        mem_ready = 1'b0;
        chk({tag, " validate"}, valid_line, 1);
        chk({tag, " done"}, done, 1);
        chk({tag, " last fill_line"}, fill_line, 1);
        chk({tag, " last line_offset"}, line_offset, so + 2'd3);
        chk({tag, " last line_in"}, line_in, data[127:96]);
        chk({tag, " validate mem_read"}, mem_read, 0);
        chk({tag, " validate fill_tag"}, fill_tag, pa[35:12]);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        chk({tag, " last crit_valid"}, crit_valid, 0);
`endif
        tick;
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle done"}, done, 0);
        chk({tag, " idle validate"}, valid_line, 0);
        chk({tag, " idle fill_line"}, fill_line, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; paddr = '0; way = '0; mem_ready = 1'b0; mem_data = '0;
        tick; tick;
        reset = 1'b0;
        chk_all_zero("reset");

        // 1: back-to-back acks
        do_fill("t1", 36'h0_1234_5678, 2'd2,
                {32'hA3A3_A3A3, 32'hA2A2_A2A2, 32'hA1A1_A1A1, 32'hA0A0_A0A0},
                16'h0000, 1'b0, 1'b0);

        // 2: gaps 0,3,1,5 and stray ready during INVAL
        do_fill("t2", 36'h0_1234_5678, 2'd2,
                {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000},
                16'h5130, 1'b0, 1'b1);

        // 3: stray acks in IDLE, then Start held across two fills
        mem_ready = 1'b1; mem_data = 32'h5555_AAAA;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk("t3 stray fill_line", fill_line, 0);
            chk("t3 stray busy", busy, 0);
        end
        mem_ready = 1'b0;
        do_fill("t3a", 36'h9_8765_4324, 2'd1,
                {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 16'h0201, 1'b1, 1'b0);
        do_fill("t3b", 36'h0_0000_0FF0, 2'd3,
                {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 16'h0000, 1'b1, 1'b0);
        start = 1'b0;
        tick;
        tick;
        chk("t3 end busy", busy, 0);

        // 4: reset after 2nd ack
        start = 1'b1; paddr = 36'h0_ABCD_EF08; way = 2'd3;
        tick;
        start = 1'b0;
        tick;
        mem_ready = 1'b1; mem_data = 32'hE000_0000;
        tick;
        mem_data = 32'hE000_0001;
        tick;
        chk("t4 pre-reset fill_line", fill_line, 1);
        reset = 1'b1; mem_ready = 1'b0;
        tick;
        reset = 1'b0;
        chk_all_zero("t4");
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk("t4 no validate", valid_line, 0);
            chk("t4 no busy", busy, 0);
            chk("t4 no fill_line", fill_line, 0);
        end
        mem_ready = 1'b0;
        do_fill("t4n", 36'h0_ABCD_EF08, 2'd3,
                {32'hF3, 32'hF2, 32'hF1, 32'hF0}, 16'h0010, 1'b0, 1'b0);

        // 5/6: CWF ordering (offset 2'b10) and back-to-back misses
        do_fill("t6a", 36'h3_0000_1238, 2'd0,
                {32'h1111_0003, 32'h1111_0002, 32'h1111_0001, 32'h1111_0000},
                16'h0000, 1'b0, 1'b0);
        do_fill("t6b", 36'h3_0000_123C, 2'd1,
                {32'h2222_0003, 32'h2222_0002, 32'h2222_0001, 32'h2222_0000},
                16'h0102, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
